// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: arbiter state encoding, requester indices
// and the memory geometry defaults shared with the main control unit.
package coproc_pkg;

   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 32;
   localparam int REQ_MAIN_CU = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GRANT = 2'b01,
      S_TURN  = 2'b10
   } arb_state_t;

   // Next round-robin index after idx, wrapping at n.
   function automatic int rr_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr,
// wrapping around. Also used by the processor result-collection logic.
module rr_priority_picker #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     request,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [IDX_W:0] sum;

   // Doubling the vector turns the wrap-around scan into a plain part-select.
   assign req_dbl = {request, request};
   assign req_rot = req_dbl[rr_ptr +: N];

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req_rot[i]) begin
            valid = 1'b1;
            sum   = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N))
               sum = sum - (IDX_W+1)'(N);
            winner = sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter for the shared coprocessor memory port; muxes the
// owner's address/data/write strobe and forces release on over-long holds.
//
// state   | meaning
// S_IDLE  | no owner, arbitrate on every edge
// S_GRANT | o_Grant one-hot, owner drives the memory port
// S_TURN  | one-cycle turnaround after a release, then arbitrates like S_IDLE
module memory_arbiter
   import coproc_pkg::*;
#(
   parameter int N_REQ    = 5,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = 64
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset,
   input  logic [N_REQ-1:0]           i_Request,
   output logic [N_REQ-1:0]           o_Grant,
   input  logic [N_REQ*ADDR_W-1:0]    i_Address,
   input  logic [N_REQ*DATA_W-1:0]    i_Write_Data,
   input  logic [N_REQ-1:0]           i_Write_Enable,
   output logic [ADDR_W-1:0]          o_Mem_Address,
   output logic [DATA_W-1:0]          o_Mem_Write_Data,
   output logic                       o_Mem_Write_Enable,
   input  logic [DATA_W-1:0]          i_Mem_Read_Data,
   output logic [DATA_W-1:0]          o_Read_Data,
   output logic [$clog2(N_REQ)-1:0]   o_Owner,
   output logic                       o_Busy
);

   localparam int OWN_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t        state;
   logic [OWN_W-1:0]  rr_ptr;
   logic [HOLD_W-1:0] hold;
   logic [OWN_W-1:0]  pick_winner;
   logic              pick_valid;
   logic [OWN_W-1:0]  next_ptr;
   logic [OWN_W-1:0]  sel;
   logic              hold_max;
   logic              others_pending;
   logic              release_now;

   rr_priority_picker #(
      .N     (N_REQ),
      .IDX_W (OWN_W)
   ) u_picker (
      .request (i_Request),
      .rr_ptr  (rr_ptr),
      .winner  (pick_winner),
      .valid   (pick_valid)
   );

   assign hold_max       = (hold == HOLD_W'(MAX_HOLD));
   assign others_pending = |(i_Request & ~o_Grant);
   assign release_now    = !i_Request[o_Owner] || (hold_max && others_pending);
   assign next_ptr       = OWN_W'(rr_wrap_inc(int'(o_Owner), N_REQ));

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state   <= S_IDLE;
         o_Grant <= '0;
         o_Busy  <= 1'b0;
         o_Owner <= '0;
         rr_ptr  <= '0;
         hold    <= '0;
      end else begin
         case (state)
            S_IDLE, S_TURN: begin
               if (pick_valid) begin
                  o_Grant <= N_REQ'(1) << pick_winner;
                  o_Owner <= pick_winner;
                  o_Busy  <= 1'b1;
                  hold    <= HOLD_W'(1);
                  state   <= S_GRANT;
               end else begin
                  state   <= S_IDLE;
               end
            end
            S_GRANT: begin
               if (release_now) begin
                  o_Grant <= '0;
                  o_Busy  <= 1'b0;
                  hold    <= '0;
                  rr_ptr  <= next_ptr;
                  state   <= S_TURN;
               end else if (!hold_max) begin
                  hold    <= hold + HOLD_W'(1);
               end
            end
            default: begin
               o_Grant <= '0;
               o_Busy  <= 1'b0;
               hold    <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // With no owner the port idles on the main control unit's slice.
   assign sel = o_Busy ? o_Owner : OWN_W'(REQ_MAIN_CU);

   assign o_Mem_Address      = i_Address[sel*ADDR_W +: ADDR_W];
   assign o_Mem_Write_Data   = i_Write_Data[sel*DATA_W +: DATA_W];
   assign o_Mem_Write_Enable = o_Busy & i_Request[o_Owner] & i_Write_Enable[o_Owner];
   assign o_Read_Data        = i_Mem_Read_Data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, round-robin order, forced release,
// hold saturation, write gating and asynchronous reset mid-grant.
module tb_memory_arbiter;

   localparam int N  = 5;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MH = 8;

   logic            i_Clock;
   logic            i_Reset;
   logic [N-1:0]    i_Request;
   logic [N-1:0]    o_Grant;
   logic [N*AW-1:0] i_Address;
   logic [N*DW-1:0] i_Write_Data;
   logic [N-1:0]    i_Write_Enable;
   logic [AW-1:0]   o_Mem_Address;
   logic [DW-1:0]   o_Mem_Write_Data;
   logic            o_Mem_Write_Enable;
   logic [DW-1:0]   i_Mem_Read_Data;
   logic [DW-1:0]   o_Read_Data;
   logic [2:0]      o_Owner;
   logic            o_Busy;

   int n_total = 0;
   int n_bad   = 0;

   memory_arbiter #(
      .N_REQ    (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_HOLD (MH)
   ) dut (
      .i_Clock            (i_Clock),
      .i_Reset            (i_Reset),
      .i_Request          (i_Request),
      .o_Grant            (o_Grant),
      .i_Address          (i_Address),
      .i_Write_Data       (i_Write_Data),
      .i_Write_Enable     (i_Write_Enable),
      .o_Mem_Address      (o_Mem_Address),
      .o_Mem_Write_Data   (o_Mem_Write_Data),
      .o_Mem_Write_Enable (o_Mem_Write_Enable),
      .i_Mem_Read_Data    (i_Mem_Read_Data),
      .o_Read_Data        (o_Read_Data),
      .o_Owner            (o_Owner),
      .o_Busy             (o_Busy)
   );

   initial begin
      i_Clock = 1'b0;
      forever #5 i_Clock = ~i_Clock;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge i_Clock);
      #2;
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      step(1);
      i_Reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order [6];
      int k;
      order = '{0, 1, 2, 3, 4, 0};

      i_Reset         = 1'b1;
      i_Request       = '0;
      i_Write_Enable  = '0;
      i_Mem_Read_Data = 32'hDEAD_BEEF;
      for (int i = 0; i < N; i++) begin
         i_Address[i*AW +: AW]    = AW'(10'h100 + i);
         i_Write_Data[i*DW +: DW] = 32'hA000_0000 + DW'(i);
      end

      // reset state and read broadcast
      step(1);
      chk("rst_grant", 64'(o_Grant), 64'h0);
      chk("rst_busy",  64'(o_Busy), 64'h0);
      chk("rst_owner", 64'(o_Owner), 64'h0);
      chk("rst_we",    64'(o_Mem_Write_Enable), 64'h0);
      chk("rd_bcast0", 64'(o_Read_Data), 64'hDEAD_BEEF);
      i_Mem_Read_Data = 32'h1234_5678;
      #1;
      chk("rd_bcast1", 64'(o_Read_Data), 64'h1234_5678);
      i_Reset = 1'b0;

      // single request
      i_Request = 5'b00001;
      #1;
      chk("t1_pre", 64'(o_Grant), 64'h0);
      step(1);
      chk("t1_grant", 64'(o_Grant), 64'h01);
      chk("t1_owner", 64'(o_Owner), 64'h0);
      chk("t1_busy",  64'(o_Busy), 64'h1);
      chk("t1_addr",  64'(o_Mem_Address), 64'h100);
      chk("t1_wdata", 64'(o_Mem_Write_Data), 64'hA000_0000);
      i_Request = 5'b00000;
      step(1);
      chk("t1_turn", 64'(o_Grant), 64'h0);
      chk("t1_turn_busy", 64'(o_Busy), 64'h0);
      step(1);
      chk("t1_idle", 64'(o_Grant), 64'h0);

      // round-robin: each owner keeps the port for 3 cycles
      do_reset();
      i_Request = 5'b11111;
      for (int j = 0; j < 6; j++) begin
         k = order[j];
         step(1);
         chk("rr_grant", 64'(o_Grant), 64'(1) << k);
         chk("rr_owner", 64'(o_Owner), 64'(k));
         step(2);
         chk("rr_hold3", 64'(o_Grant), 64'(1) << k);
         i_Request[k] = 1'b0;
         step(1);
         chk("rr_gap", 64'(o_Grant), 64'h0);
         i_Request[k] = 1'b1;
      end
      i_Request = '0;
      step(2);

      // forced release after MAX_HOLD grant cycles
      do_reset();
      i_Request = 5'b00100;
      step(1);
      chk("fr_grant", 64'(o_Grant), 64'h04);
      step(2);
      i_Request[3] = 1'b1;
      step(5);
      chk("fr_hold8", 64'(o_Grant), 64'h04);
      step(1);
      chk("fr_release", 64'(o_Grant), 64'h0);
      step(1);
      chk("fr_next", 64'(o_Grant), 64'h08);
      chk("fr_owner", 64'(o_Owner), 64'h3);
      i_Request = '0;
      step(2);

      // hold saturates with no competitor
      do_reset();
      i_Request = 5'b00010;
      step(1);
      for (int j = 0; j < 20; j++) begin
         chk("sat_grant", 64'(o_Grant), 64'h02);
         step(1);
      end
      i_Request = '0;
      step(2);

      // write gating
      do_reset();
      i_Address[4*AW +: AW] = 10'h001;
      i_Request = 5'b00001;
      step(1);
      chk("wg_grant0", 64'(o_Grant), 64'h01);
      i_Request[4]      = 1'b1;
      i_Write_Enable[4] = 1'b1;
      #1;
      chk("wg_pre_we", 64'(o_Mem_Write_Enable), 64'h0);
      i_Request[0] = 1'b0;
      step(1);
      chk("wg_turn_grant", 64'(o_Grant), 64'h0);
      chk("wg_turn_we", 64'(o_Mem_Write_Enable), 64'h0);
      step(1);
      chk("wg_grant4", 64'(o_Grant), 64'h10);
      chk("wg_we", 64'(o_Mem_Write_Enable), 64'h1);
      chk("wg_addr", 64'(o_Mem_Address), 64'h001);
      chk("wg_wdata", 64'(o_Mem_Write_Data), 64'hA000_0004);
      i_Request      = '0;
      i_Write_Enable = '0;
      i_Address[4*AW +: AW] = 10'h104;
      step(2);

      // asynchronous reset while owner 1 writes
      do_reset();
      i_Request         = 5'b00010;
      i_Write_Enable[1] = 1'b1;
      step(1);
      chk("ar_grant", 64'(o_Grant), 64'h02);
      chk("ar_we", 64'(o_Mem_Write_Enable), 64'h1);
      #1;
      i_Reset = 1'b1;
      #1;
      chk("ar_grant_drop", 64'(o_Grant), 64'h0);
      chk("ar_we_drop", 64'(o_Mem_Write_Enable), 64'h0);
      chk("ar_busy_drop", 64'(o_Busy), 64'h0);
      i_Request = 5'b01010;
      step(1);
      i_Reset = 1'b0;
      step(1);
      chk("ar_regrant", 64'(o_Grant), 64'h02);
      chk("ar_owner", 64'(o_Owner), 64'h1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
